// File: rtl/l1_trigger_scheduler_pkg.sv
// Shared types and constants for the L1 trigger scheduler.
//   state_t   : scheduler FSM states
//   TS_LSB / BEAM_LSB / BEAM_W : trigger record field layout
//   DROP_SAT  : saturation value of the dropped-trigger counter
package l1_trig_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    HOLDOFF
  } state_t;

  localparam int unsigned REC_W    = 64;
  localparam int unsigned TS_LSB   = 0;
  localparam int unsigned BEAM_LSB = 48;
  localparam int unsigned BEAM_W   = 8;
  localparam int unsigned DROP_W   = 16;

  localparam logic [DROP_W-1:0] DROP_SAT = '1;

endpackage

// File: rtl/l1_trigger_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req : request vector
//   ptr : search start position (highest priority this cycle), must be < N
//   gnt : one-hot grant
//   idx : binary index of the granted request
//   any : at least one request present
module rr_arbiter #(
  parameter  int unsigned N  = 2,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  int unsigned j;
  logic [PW-1:0] jj;

  // Walk upward from ptr, wrapping modulo N; the first set request wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    jj  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = 32'(ptr) + i;
      if (j >= N) j = j - N;
      jj = j[PW-1:0];
      if (!any && req[jj]) begin
        any     = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

endmodule

// File: rtl/l1_trigger_scheduler.sv
// L1 trigger scheduler: latches qualified per-beam triggers, grants them
// round-robin, stamps each with a free-running timestamp, emits one 64-bit
// record per grant on an AXI4-Stream master, then applies a global holdoff.
//   aclk, reset_i       : clock, synchronous active-high reset
//   trig_i, mask_i      : per-beam trigger levels and allow mask
//   enable_i            : global trigger enable
//   holdoff_i           : post-trigger dead time in cycles
//   trig_tdata/tvalid/tready : record stream
//   busy_o              : FSM not idle
//   pending_o           : pending-trigger register
//   dropped_o           : saturating count of discarded triggers
module l1_trigger_scheduler
  import l1_trig_pkg::*;
#(
  parameter int unsigned NBEAMS       = 2,
  parameter int unsigned TS_BITS      = 48,
  parameter int unsigned HOLDOFF_BITS = 16
) (
  input  logic                    aclk,
  input  logic                    reset_i,
  input  logic [NBEAMS-1:0]       trig_i,
  input  logic [NBEAMS-1:0]       mask_i,
  input  logic                    enable_i,
  input  logic [HOLDOFF_BITS-1:0] holdoff_i,
  output logic [REC_W-1:0]        trig_tdata,
  output logic                    trig_tvalid,
  input  logic                    trig_tready,
  output logic                    busy_o,
  output logic [NBEAMS-1:0]       pending_o,
  output logic [DROP_W-1:0]       dropped_o
);

  localparam int unsigned PW = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;

  state_t                  state;
  logic [TS_BITS-1:0]      ts;
  logic [NBEAMS-1:0]       pending;
  logic [NBEAMS-1:0]       pending_next;
  logic [NBEAMS-1:0]       q;
  logic [NBEAMS-1:0]       gnt;
  logic [NBEAMS-1:0]       clr;
  logic [PW-1:0]           ptr;
  logic [PW-1:0]           idx;
  logic                    any;
  logic                    grant_en;
  logic                    drop_ev;
  logic [HOLDOFF_BITS-1:0] hold_cnt;
  logic [REC_W-1:0]        rec_next;

  rr_arbiter #(.N(NBEAMS)) u_arb (
    .req (pending),
    .ptr (ptr),
    .gnt (gnt),
    .idx (idx),
    .any (any)
  );

  assign q         = trig_i & mask_i & {NBEAMS{enable_i}};
  assign grant_en  = (state == IDLE) && enable_i && any;
  assign clr       = grant_en ? gnt : '0;
  assign busy_o    = (state != IDLE);
  assign pending_o = pending;

  // A beam re-granted and re-triggered in the same cycle stays pending
  // without counting a drop, since clr masks it out of the overlap test.
  always_comb begin
    drop_ev      = 1'b0;
    pending_next = pending;
    case (state)
      HOLDOFF: drop_ev = |q;
      default: begin
        drop_ev = |(q & pending & ~clr);
        if (state == IDLE && !enable_i) pending_next = '0;
        else                            pending_next = (pending & ~clr) | q;
      end
    endcase
  end

  always_comb begin
    rec_next = '0;
    rec_next[TS_LSB +: TS_BITS]  = ts;
    rec_next[BEAM_LSB +: BEAM_W] = BEAM_W'(idx);
  end

  always_ff @(posedge aclk) begin
    if (reset_i) begin
      state       <= IDLE;
      trig_tvalid <= 1'b0;
      trig_tdata  <= '0;
      pending     <= '0;
      dropped_o   <= '0;
      ts          <= '0;
      ptr         <= '0;
      hold_cnt    <= '0;
    end else begin
      ts      <= ts + 1'b1;
      pending <= pending_next;
      if (drop_ev && dropped_o != DROP_SAT) dropped_o <= dropped_o + 1'b1;

      case (state)
        IDLE: begin
          if (grant_en) begin
            trig_tdata  <= rec_next;
            trig_tvalid <= 1'b1;
            ptr         <= (idx == PW'(NBEAMS - 1)) ? '0 : idx + 1'b1;
            state       <= EMIT;
          end
        end
        EMIT: begin
          if (trig_tready) begin
            trig_tvalid <= 1'b0;
            if (holdoff_i == '0) begin
              state <= IDLE;
            end else begin
              hold_cnt <= holdoff_i;
              state    <= HOLDOFF;
            end
          end
        end
        HOLDOFF: begin
          if (hold_cnt == HOLDOFF_BITS'(1)) state    <= IDLE;
          else                              hold_cnt <= hold_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_trigger_scheduler.sv
// Scoreboard bench for l1_trigger_scheduler: stimulus pushes expected records,
// a negedge monitor pops and compares them at each handshake.
module tb_l1_trigger_scheduler;

  logic        aclk = 1'b0;
  logic        reset_i;
  logic [1:0]  trig_i;
  logic [1:0]  mask_i;
  logic        enable_i;
  logic [15:0] holdoff_i;
  logic [63:0] trig_tdata;
  logic        trig_tvalid;
  logic        trig_tready;
  logic        busy_o;
  logic [1:0]  pending_o;
  logic [15:0] dropped_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [63:0] exp_q[$];
  logic        stall_prev = 1'b0;
  logic [63:0] held;

  always #5 aclk = ~aclk;

  l1_trigger_scheduler #(.NBEAMS(2), .TS_BITS(48), .HOLDOFF_BITS(16)) dut (
    .aclk        (aclk),
    .reset_i     (reset_i),
    .trig_i      (trig_i),
    .mask_i      (mask_i),
    .enable_i    (enable_i),
    .holdoff_i   (holdoff_i),
    .trig_tdata  (trig_tdata),
    .trig_tvalid (trig_tvalid),
    .trig_tready (trig_tready),
    .busy_o      (busy_o),
    .pending_o   (pending_o),
    .dropped_o   (dropped_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
    cyc++;
  endtask

  function automatic logic [63:0] rec(input logic [7:0] beam, input logic [47:0] t);
    return {8'h00, beam, t};
  endfunction

  task automatic do_reset();
    reset_i     = 1'b1;
    trig_i      = 2'b00;
    mask_i      = 2'b11;
    enable_i    = 1'b1;
    holdoff_i   = 16'd0;
    trig_tready = 1'b1;
    step();
    step();
    exp_q.delete();
    reset_i = 1'b0;
    cyc     = 0;
  endtask

  // Monitor: compare at each handshake, and hold tdata stable while stalled.
  always @(negedge aclk) begin
    if (!reset_i && trig_tvalid) begin
      if (stall_prev) chk("stall_stable", trig_tdata, held);
      if (trig_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_record: got %h expected none", trig_tdata);
        end else begin
          chk("record", trig_tdata, exp_q.pop_front());
        end
        stall_prev <= 1'b0;
      end else begin
        held       <= trig_tdata;
        stall_prev <= 1'b1;
      end
    end else begin
      stall_prev <= 1'b0;
    end
  end

  initial begin
    int c;
    int vc;
    int bc;

    // Reset state
    do_reset();
    chk("rst_tvalid", 64'(trig_tvalid), 64'd0);
    chk("rst_tdata", trig_tdata, 64'd0);
    chk("rst_pending", 64'(pending_o), 64'd0);
    chk("rst_dropped", 64'(dropped_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);

    // Single beam: trigger sampled when timestamp reads 10 -> stamp 11
    repeat (10) step();
    trig_i = 2'b10;
    step();
    trig_i = 2'b00;
    exp_q.push_back(64'h0001_0000_0000_000B);
    vc = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (trig_tvalid) vc++;
    end
    chk("single_valid_cycles", 64'(vc), 64'd1);
    chk("single_pending", 64'(pending_o), 64'd0);

    // Round-robin, twice (pointer must wrap back to beam 0)
    do_reset();
    repeat (3) step();
    for (int r = 0; r < 2; r++) begin
      c = cyc;
      trig_i = 2'b11;
      step();
      trig_i = 2'b00;
      exp_q.push_back(rec(8'd0, 48'(c + 1)));
      exp_q.push_back(rec(8'd1, 48'(c + 3)));
      repeat (6) step();
    end
    chk("rr_drain", 64'(exp_q.size()), 64'd0);

    // Backpressure: stall, latch one retrigger, drop a second one
    do_reset();
    trig_tready = 1'b0;
    step();
    c = cyc;
    trig_i = 2'b01;
    step();
    trig_i = 2'b00;
    exp_q.push_back(rec(8'd0, 48'(c + 1)));
    step();
    chk("bp_valid", 64'(trig_tvalid), 64'd1);
    trig_i = 2'b01;
    step();
    trig_i = 2'b00;
    chk("bp_latch", 64'(pending_o), 64'd1);
    chk("bp_no_drop", 64'(dropped_o), 64'd0);
    trig_i = 2'b01;
    step();
    trig_i = 2'b00;
    chk("bp_drop", 64'(dropped_o), 64'd1);
    repeat (16) step();
    trig_tready = 1'b1;
    exp_q.push_back(rec(8'd0, 48'(cyc + 1)));
    repeat (6) step();
    chk("bp_pending", 64'(pending_o), 64'd0);
    chk("bp_tvalid", 64'(trig_tvalid), 64'd0);
    chk("bp_dropped", 64'(dropped_o), 64'd1);
    chk("bp_drain", 64'(exp_q.size()), 64'd0);

    // Holdoff of 5 with three trigger cycles inside it
    do_reset();
    holdoff_i = 16'd5;
    c = cyc;
    trig_i = 2'b01;
    step();
    trig_i = 2'b00;
    exp_q.push_back(rec(8'd0, 48'(c + 1)));
    step();
    step();
    holdoff_i = 16'd1;
    bc = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy_o) bc++;
      trig_i = (i < 3) ? 2'b01 : 2'b00;
      step();
    end
    chk("ho_busy_cycles", 64'(bc), 64'd5);
    chk("ho_dropped", 64'(dropped_o), 64'd3);
    chk("ho_pending", 64'(pending_o), 64'd0);
    chk("ho_drain", 64'(exp_q.size()), 64'd0);

    // Mask blocks beam 1
    do_reset();
    mask_i = 2'b01;
    trig_i = 2'b10;
    step();
    trig_i = 2'b00;
    vc = 0;
    repeat (5) begin
      step();
      if (trig_tvalid) vc++;
    end
    chk("mask_no_record", 64'(vc), 64'd0);
    chk("mask_pending", 64'(pending_o), 64'd0);
    mask_i = 2'b11;

    // Enable dropped while a record is stalled with beam 1 pending
    trig_tready = 1'b0;
    c = cyc;
    trig_i = 2'b01;
    step();
    trig_i = 2'b00;
    exp_q.push_back(rec(8'd0, 48'(c + 1)));
    step();
    trig_i = 2'b10;
    step();
    trig_i = 2'b00;
    chk("en_pending_set", 64'(pending_o), 64'd2);
    enable_i = 1'b0;
    step();
    step();
    trig_tready = 1'b1;
    repeat (6) step();
    chk("en_pending_clr", 64'(pending_o), 64'd0);
    chk("en_tvalid", 64'(trig_tvalid), 64'd0);
    chk("en_dropped", 64'(dropped_o), 64'd0);
    chk("en_drain", 64'(exp_q.size()), 64'd0);
    enable_i = 1'b1;

    // Reset in the middle of a stalled record
    do_reset();
    trig_tready = 1'b0;
    trig_i = 2'b01;
    step();
    trig_i = 2'b00;
    step();
    chk("rm_valid_pre", 64'(trig_tvalid), 64'd1);
    trig_i = 2'b10;
    step();
    step();
    trig_i = 2'b00;
    chk("rm_dropped_pre", 64'(dropped_o), 64'd1);
    reset_i = 1'b1;
    step();
    chk("rm_tvalid", 64'(trig_tvalid), 64'd0);
    chk("rm_dropped", 64'(dropped_o), 64'd0);
    chk("rm_pending", 64'(pending_o), 64'd0);
    chk("rm_busy", 64'(busy_o), 64'd0);
    reset_i = 1'b0;
    cyc = 0;
    trig_tready = 1'b1;
    trig_i = 2'b01;
    step();
    trig_i = 2'b00;
    exp_q.push_back(rec(8'd0, 48'd1));
    repeat (4) step();
    chk("rm_drain", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
